// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - segment bit positions and hex glyph table for the scanning display
package seg_pkg;

  localparam int SEG_A   = 0;
  localparam int SEG_B   = 1;
  localparam int SEG_C   = 2;
  localparam int SEG_D   = 3;
  localparam int SEG_E   = 4;
  localparam int SEG_F   = 5;
  localparam int SEG_G   = 6;
  localparam int SEG_DP  = 7;
  localparam int SEG_LIT = 8;

  // Segment a is bit 0; entry n is the glyph for hex digit n.
  localparam logic [6:0] GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return GLYPHS[nibble];
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// rtl/seg_hex_decoder.sv - combinational hex nibble to seven-segment glyph
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = hex_to_seg(nibble);

endmodule

// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - multiplexed seven-segment scanner with frame-aligned double buffer
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 12000,
  parameter int BLANK_CYC  = 2,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp,
  input  logic                      load,
  output logic [8:0]                seg,
  output logic [NUM_DIGITS-1:0]     dig_sel,
  output logic                      frame_start
);

  localparam int   PW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int   IW  = $clog2(NUM_DIGITS);
  localparam logic INV = (ACTIVE_LOW != 0);

  logic [PW-1:0]           pcnt, pcnt_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [4*NUM_DIGITS-1:0] pend_val, act_val, act_val_nxt;
  logic [NUM_DIGITS-1:0]   pend_dp, act_dp, act_dp_nxt;
  logic                    tick, commit, window, blank;
  logic [3:0]              nib;
  logic [6:0]              glyph;
  logic [7:0]              seg_raw;
  logic [NUM_DIGITS-1:0]   dig_raw;

  assign tick     = (pcnt == PW'(SCAN_DIV - 1));
  assign commit   = tick && (idx == IW'(NUM_DIGITS - 1));
  assign pcnt_nxt = tick ? '0 : pcnt + 1'b1;
  assign idx_nxt  = commit ? '0 : (tick ? idx + 1'b1 : idx);

  // Output registers are loaded from next-state values so the pins track pcnt with no extra lag.
  assign act_val_nxt = commit ? (load ? value : pend_val) : act_val;
  assign act_dp_nxt  = commit ? (load ? dp : pend_dp) : act_dp;
  assign nib         = act_val_nxt[{idx_nxt, 2'b00} +: 4];
  assign window      = !(pcnt_nxt < PW'(BLANK_CYC));

  seg_hex_decoder u_dec (
    .nibble (nib),
    .glyph  (glyph)
  );

`ifdef SEG_LZB_EN
  logic [NUM_DIGITS-1:0] lead_zero;

  always_comb begin
    lead_zero = '0;
    lead_zero[NUM_DIGITS-1] = (act_val_nxt[4*NUM_DIGITS-1 -: 4] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      lead_zero[i] = (act_val_nxt[i*4 +: 4] == 4'h0) && lead_zero[i+1];
    end
  end

  assign blank = lead_zero[idx_nxt] && (idx_nxt != '0);
`else
  assign blank = 1'b0;
`endif

  assign seg_raw = window ? {act_dp_nxt[idx_nxt], (blank ? 7'h00 : glyph)} : 8'h00;
  assign dig_raw = window ? (NUM_DIGITS'(1) << idx_nxt) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt        <= '0;
      idx         <= '0;
      pend_val    <= '0;
      pend_dp     <= '0;
      act_val     <= '0;
      act_dp      <= '0;
      seg         <= {1'b0, {8{INV}}};
      dig_sel     <= {NUM_DIGITS{INV}};
      frame_start <= 1'b0;
    end else begin
      pcnt    <= pcnt_nxt;
      idx     <= idx_nxt;
      act_val <= act_val_nxt;
      act_dp  <= act_dp_nxt;
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp;
      end
      seg[SEG_LIT]    <= |seg_raw;
      seg[SEG_DP:0]   <= seg_raw ^ {8{INV}};
      dig_sel         <= dig_raw ^ {NUM_DIGITS{INV}};
      frame_start     <= commit;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// tb/tb_seg_scan_display.sv - directed self-checking bench for seg_scan_display
`timescale 1ns/1ps
module tb_seg_scan_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic        load = 1'b0;
  logic [8:0]  seg, seg_inv;
  logic [3:0]  dig_sel, dig_inv;
  logic        frame_start, fs_inv;

  int checks = 0;
  int failures = 0;

  always #41.667 clk = ~clk;

  seg_scan_display #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2), .ACTIVE_LOW(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .load(load),
    .seg(seg), .dig_sel(dig_sel), .frame_start(frame_start)
  );

  seg_scan_display #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2), .ACTIVE_LOW(1)) u_inv (
    .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .load(load),
    .seg(seg_inv), .dig_sel(dig_inv), .frame_start(fs_inv)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp    = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 100);
    check("frame_start_timeout", {31'd0, frame_start}, 32'd1);
  endtask

  // Call on the first cycle of a frame; e holds {slot3, slot2, slot1, slot0} expected seg words.
  task automatic check_frame(input string tag, input logic [35:0] e, input logic exp_fs);
    logic [8:0] es;
    logic [3:0] ed;
    for (int c = 0; c < 32; c++) begin
      if (c > 0) @(negedge clk);
      if ((c % 8) < 2) begin
        es = 9'h000;
        ed = 4'b0000;
      end else begin
        es = e[(c/8)*9 +: 9];
        ed = 4'b0001 << (c/8);
      end
      check({tag, "_seg"}, {23'd0, seg}, {23'd0, es});
      check({tag, "_dig"}, {28'd0, dig_sel}, {28'd0, ed});
      check({tag, "_fs"}, {31'd0, frame_start}, {31'd0, (c == 0) ? exp_fs : 1'b0});
      check({tag, "_inv_seg"}, {23'd0, seg_inv}, {23'd0, es[8], ~es[7:0]});
      check({tag, "_inv_dig"}, {28'd0, dig_inv}, {28'd0, ~ed});
    end
  endtask

  initial begin
    #100;
    check("rst_seg", {23'd0, seg}, 32'h000);
    check("rst_dig", {28'd0, dig_sel}, 32'h0);
    check("rst_fs", {31'd0, frame_start}, 32'd0);
    check("rst_inv_seg", {23'd0, seg_inv}, 32'h0FF);
    check("rst_inv_dig", {28'd0, dig_inv}, 32'hF);

    @(negedge clk);
    rst_n = 1'b1;
    check_frame("boot", {9'h13F, 9'h13F, 9'h13F, 9'h13F}, 1'b0);

    // Load mid-frame during slot 1; slot 2 must still show the old value.
    wait_frame();
    repeat (10) @(negedge clk);
    do_load(16'h1234, 4'b0010);
    repeat (8) @(negedge clk);
    check("no_tear_seg", {23'd0, seg}, 32'h13F);
    check("no_tear_dig", {28'd0, dig_sel}, 32'h4);
    wait_frame();
    check_frame("v1234", {9'h106, 9'h15B, 9'h1CF, 9'h166}, 1'b1);

    // Now on the commit cycle: this load must bypass straight into the next frame.
    do_load(16'hABCD, 4'b0000);
    check_frame("collide", {9'h177, 9'h17C, 9'h139, 9'h15E}, 1'b1);

`ifdef SEG_LZB_EN
    do_load(16'h0050, 4'b1000);
    check_frame("lzb50", {9'h180, 9'h000, 9'h16D, 9'h13F}, 1'b1);
    do_load(16'h0000, 4'b0000);
    check_frame("lzb0", {9'h000, 9'h000, 9'h000, 9'h13F}, 1'b1);
`else
    do_load(16'h0050, 4'b1000);
    check_frame("nolzb50", {9'h1BF, 9'h13F, 9'h16D, 9'h13F}, 1'b1);
    do_load(16'h0000, 4'b0000);
    check_frame("nolzb0", {9'h13F, 9'h13F, 9'h13F, 9'h13F}, 1'b1);
`endif

    do_load(16'h8888, 4'b0000);
    check_frame("v8888", {9'h17F, 9'h17F, 9'h17F, 9'h17F}, 1'b1);

    // Asynchronous reset in the middle of slot 2.
    repeat (20) @(negedge clk);
    check("pre_rst_dig", {28'd0, dig_sel}, 32'h4);
    check("pre_rst_seg", {23'd0, seg}, 32'h17F);
    #10;
    rst_n = 1'b0;
    #1;
    check("async_seg", {23'd0, seg}, 32'h000);
    check("async_dig", {28'd0, dig_sel}, 32'h0);
    check("async_inv_seg", {23'd0, seg_inv}, 32'h0FF);
    check("async_inv_dig", {28'd0, dig_inv}, 32'hF);
    @(negedge clk);
    rst_n = 1'b1;
    check_frame("restart", {9'h13F, 9'h13F, 9'h13F, 9'h13F}, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
